// File: rtl/tb_pin_stim_gen.sv
// Multi-channel pin stimulus generator: hold / LFSR-random / periodic / one-shot pulse per channel,
// all channels sharing one seeded 32-bit Galois LFSR; pin_o and toggle_o update on the same edge.
module tb_pin_stim_gen #(
   parameter int          CH       = 2,
   parameter int          CNT_W    = 16,
   parameter logic [31:0] SEED_DEF = 32'hACE1_2468,
   parameter logic        RST_LVL  = 1'b1
) (
   input  logic                                   sys_clk,
   input  logic                                   sys_rst,
   input  logic                                   enable,
   input  logic                                   seed_load,
   input  logic [31:0]                            seed_val,
   input  logic                                   cfg_wr,
   input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] cfg_ch,
   input  logic [1:0]                             cfg_mode,
   input  logic [CNT_W-1:0]                       cfg_period,
   input  logic                                   cfg_init,
   output logic [CH-1:0]                          pin_o,
   output logic [CH-1:0]                          toggle_o,
   output logic [CH-1:0]                          done_o,
   output logic [CNT_W-1:0]                       toggle_cnt
);
   localparam int          CH_W  = (CH > 1) ? $clog2(CH) : 1;
   localparam int          SUM_W = CNT_W + 6;
   localparam logic [31:0] TAPS  = 32'h8020_0003;

   typedef enum logic [1:0] {M_HOLD, M_RANDOM, M_PERIODIC, M_PULSE} mode_t;

   logic [31:0]      lfsr, lfsr_nxt;
   mode_t            mode [CH];
   mode_t            mode_nxt [CH];
   logic [CNT_W-1:0] period [CH];
   logic [CNT_W-1:0] period_nxt [CH];
   logic [CNT_W-1:0] cnt [CH];
   logic [CNT_W-1:0] cnt_nxt [CH];
   logic [CNT_W-1:0] rnd [CH];
   logic [CH-1:0]    init, init_nxt, pin_nxt, tog_nxt, done_nxt;
   logic [SUM_W-1:0] cnt_sum;
   logic [CNT_W-1:0] toggle_cnt_nxt;

   always_comb begin
      lfsr_nxt = lfsr;
      if (seed_load)
         lfsr_nxt = (seed_val == 32'd0) ? SEED_DEF : seed_val;
      else if (enable)
         lfsr_nxt = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'd0);

      init_nxt = init;
      pin_nxt  = pin_o;
      done_nxt = done_o;
      tog_nxt  = '0;
      cnt_sum  = SUM_W'(toggle_cnt);
      for (int c = 0; c < CH; c++) begin
         mode_nxt[c]   = mode[c];
         period_nxt[c] = period[c];
         cnt_nxt[c]    = cnt[c];
         rnd[c]        = '0;
         // Per-channel random value: pre-shift LFSR rotated left by 7*c.
         for (int i = 0; i < CNT_W; i++)
            rnd[c][i] = lfsr[(i + 32 - ((7 * c) % 32)) % 32];

         if (cfg_wr && cfg_ch == CH_W'(c)) begin
            mode_nxt[c]   = mode_t'(cfg_mode);
            period_nxt[c] = cfg_period;
            init_nxt[c]   = cfg_init;
            pin_nxt[c]    = cfg_init;
            done_nxt[c]   = 1'b0;
            case (mode_t'(cfg_mode))
               M_PERIODIC, M_PULSE: cnt_nxt[c] = cfg_period;
               M_RANDOM:            cnt_nxt[c] = rnd[c] & cfg_period;
               default:             cnt_nxt[c] = '0;
            endcase
         end else if (mode[c] == M_PULSE && !done_o[c] && pin_o[c] != init[c]) begin
            // Pulse return step is not gated by enable.
            pin_nxt[c]  = init[c];
            done_nxt[c] = 1'b1;
            cnt_nxt[c]  = '0;
            tog_nxt[c]  = 1'b1;
         end else if (enable && mode[c] != M_HOLD && !done_o[c]) begin
            if (cnt[c] != '0) begin
               cnt_nxt[c] = cnt[c] - CNT_W'(1);
            end else begin
               tog_nxt[c] = 1'b1;
               case (mode[c])
                  M_PERIODIC: begin
                     pin_nxt[c] = ~pin_o[c];
                     cnt_nxt[c] = period[c];
                  end
                  M_RANDOM: begin
                     pin_nxt[c] = ~pin_o[c];
                     cnt_nxt[c] = rnd[c] & period[c];
                  end
                  default: pin_nxt[c] = ~init[c];
               endcase
            end
         end
         cnt_sum = cnt_sum + SUM_W'(tog_nxt[c]);
      end
      toggle_cnt_nxt = (cnt_sum > SUM_W'({CNT_W{1'b1}})) ? '1 : cnt_sum[CNT_W-1:0];
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         lfsr       <= SEED_DEF;
         pin_o      <= {CH{RST_LVL}};
         init       <= {CH{RST_LVL}};
         toggle_o   <= '0;
         done_o     <= '0;
         toggle_cnt <= '0;
         for (int c = 0; c < CH; c++) begin
            mode[c]   <= M_HOLD;
            period[c] <= '0;
            cnt[c]    <= '0;
         end
      end else begin
         lfsr       <= lfsr_nxt;
         pin_o      <= pin_nxt;
         init       <= init_nxt;
         toggle_o   <= tog_nxt;
         done_o     <= done_nxt;
         toggle_cnt <= toggle_cnt_nxt;
         for (int c = 0; c < CH; c++) begin
            mode[c]   <= mode_nxt[c];
            period[c] <= period_nxt[c];
            cnt[c]    <= cnt_nxt[c];
         end
      end
   end
endmodule
